// File: rtl/cpu_program_loader.sv
// Boot loader: decodes header-framed host bursts into instruction/data memory writes, then enables the cpu.
// Optional running write checksum output is built when CPU_LOADER_CHECKSUM_EN is defined.
module cpu_program_loader #(
   parameter int IMEM_WORDS = 512,
   parameter int DMEM_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic [63:0] imem_addr,
   output logic        imem_wen,
   output logic [31:0] imem_wdata,
   output logic [63:0] dmem_addr,
   output logic        dmem_wen,
   output logic [63:0] dmem_wdata,
   output logic        cpu_enable,
   output logic        busy,
   output logic        err
`ifdef CPU_LOADER_CHECKSUM_EN
  ,output logic [31:0] checksum
`endif
);

   localparam logic [16:0] IMEM_DEPTH = 17'(IMEM_WORDS);
   localparam logic [16:0] DMEM_DEPTH = 17'(DMEM_WORDS);

   typedef enum logic [2:0] {
      ST_HDR     = 3'd0,
      ST_LOAD_LO = 3'd1,
      ST_LOAD_HI = 3'd2,
      ST_SKIP    = 3'd3,
      ST_RUN     = 3'd4
   } state_t;

   state_t      state_r;
   logic        in_ready_r;
   logic        busy_r;
   logic        err_r;
   logic        cpu_enable_r;
   logic        imem_wen_r;
   logic [63:0] imem_addr_r;
   logic [31:0] imem_wdata_r;
   logic        dmem_wen_r;
   logic [63:0] dmem_addr_r;
   logic [63:0] dmem_wdata_r;
   logic        target_r;
   logic [16:0] ptr_r;
   logic [15:0] remaining_r;
   logic [16:0] skip_r;
   logic [31:0] low_r;

   logic        beat_s;
   logic        hdr_target_s;
   logic        hdr_start_s;
   logic [13:0] hdr_base_s;
   logic [15:0] hdr_count_s;
   logic [16:0] hdr_end_s;
   logic [16:0] hdr_limit_s;
   logic        hdr_oob_s;
   logic [16:0] hdr_skip_s;
   logic        imem_fire_s;
   logic        dmem_fire_s;
   logic        last_word_s;

   assign in_ready   = in_ready_r;
   assign busy       = busy_r;
   assign err        = err_r;
   assign cpu_enable = cpu_enable_r;
   assign imem_wen   = imem_wen_r;
   assign imem_addr  = imem_addr_r;
   assign imem_wdata = imem_wdata_r;
   assign dmem_wen   = dmem_wen_r;
   assign dmem_addr  = dmem_addr_r;
   assign dmem_wdata = dmem_wdata_r;

   // Header field decode, range check and write-strobe qualification.
   always_comb begin
      beat_s       = in_valid & in_ready_r;
      hdr_target_s = in_data[31];
      hdr_start_s  = in_data[30];
      hdr_base_s   = in_data[29:16];
      hdr_count_s  = in_data[15:0];
      // 17-bit sum so B+N can never wrap past the depth check
      hdr_end_s    = {3'b000, hdr_base_s} + {1'b0, hdr_count_s};
      if (hdr_target_s) begin
         hdr_limit_s = DMEM_DEPTH;
         hdr_skip_s  = {hdr_count_s, 1'b0};
      end else begin
         hdr_limit_s = IMEM_DEPTH;
         hdr_skip_s  = {1'b0, hdr_count_s};
      end
      hdr_oob_s    = (hdr_end_s > hdr_limit_s);
      imem_fire_s  = beat_s & (state_r == ST_LOAD_LO) & ~target_r;
      dmem_fire_s  = beat_s & (state_r == ST_LOAD_HI);
      last_word_s  = (remaining_r == 16'd1);
   end

   // Loader state machine with registered handshake, status and memory-write outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_HDR;
         in_ready_r   <= 1'b1;
         busy_r       <= 1'b0;
         err_r        <= 1'b0;
         cpu_enable_r <= 1'b0;
         imem_wen_r   <= 1'b0;
         imem_addr_r  <= 64'd0;
         imem_wdata_r <= 32'd0;
         dmem_wen_r   <= 1'b0;
         dmem_addr_r  <= 64'd0;
         dmem_wdata_r <= 64'd0;
         target_r     <= 1'b0;
         ptr_r        <= 17'd0;
         remaining_r  <= 16'd0;
         skip_r       <= 17'd0;
         low_r        <= 32'd0;
      end else begin
         imem_wen_r <= 1'b0;
         dmem_wen_r <= 1'b0;
         case (state_r)
            ST_HDR: begin
               if (beat_s) begin
                  if (hdr_start_s) begin
                     state_r      <= ST_RUN;
                     in_ready_r   <= 1'b0;
                     cpu_enable_r <= 1'b1;
                     busy_r       <= 1'b0;
                  end else if (hdr_count_s == 16'd0) begin
                     state_r <= ST_HDR;
                  end else if (hdr_oob_s) begin
                     err_r   <= 1'b1;
                     skip_r  <= hdr_skip_s;
                     busy_r  <= 1'b1;
                     state_r <= ST_SKIP;
                  end else begin
                     target_r    <= hdr_target_s;
                     ptr_r       <= {3'b000, hdr_base_s};
                     remaining_r <= hdr_count_s;
                     busy_r      <= 1'b1;
                     state_r     <= ST_LOAD_LO;
                  end
               end
            end
            ST_LOAD_LO: begin
               if (imem_fire_s) begin
                  imem_wen_r   <= 1'b1;
                  imem_addr_r  <= {45'd0, ptr_r, 2'b00};
                  imem_wdata_r <= in_data;
                  ptr_r        <= ptr_r + 17'd1;
                  remaining_r  <= remaining_r - 16'd1;
                  if (last_word_s) begin
                     state_r <= ST_HDR;
                     busy_r  <= 1'b0;
                  end
               end else if (beat_s) begin
                  low_r   <= in_data;
                  state_r <= ST_LOAD_HI;
               end
            end
            ST_LOAD_HI: begin
               if (dmem_fire_s) begin
                  dmem_wen_r   <= 1'b1;
                  dmem_addr_r  <= {44'd0, ptr_r, 3'b000};
                  dmem_wdata_r <= {in_data, low_r};
                  ptr_r        <= ptr_r + 17'd1;
                  remaining_r  <= remaining_r - 16'd1;
                  if (last_word_s) begin
                     state_r <= ST_HDR;
                     busy_r  <= 1'b0;
                  end else begin
                     state_r <= ST_LOAD_LO;
                  end
               end
            end
            ST_SKIP: begin
               if (beat_s) begin
                  skip_r <= skip_r - 17'd1;
                  if (skip_r == 17'd1) begin
                     state_r <= ST_HDR;
                     busy_r  <= 1'b0;
                  end
               end
            end
            ST_RUN: begin
               in_ready_r   <= 1'b0;
               cpu_enable_r <= 1'b1;
            end
            default: begin
               state_r    <= ST_HDR;
               in_ready_r <= 1'b1;
               busy_r     <= 1'b0;
            end
         endcase
      end
   end

`ifdef CPU_LOADER_CHECKSUM_EN
   logic [31:0] checksum_r;

   assign checksum = checksum_r;

   function automatic logic [31:0] csum_add(input logic [31:0] acc,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
      return acc + a + b;
   endfunction

   // Running modulo-2^32 sum of written payload, updated with the write pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         checksum_r <= 32'd0;
      end else if (imem_fire_s) begin
         checksum_r <= csum_add(checksum_r, in_data, 32'd0);
      end else if (dmem_fire_s) begin
         checksum_r <= csum_add(checksum_r, in_data, low_r);
      end
   end
`endif

endmodule

// File: tb/tb_cpu_program_loader.sv
// Scoreboard bench for cpu_program_loader: stimulus queues expected writes, a negedge monitor checks them.
module tb_cpu_program_loader;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [63:0] imem_addr;
   logic        imem_wen;
   logic [31:0] imem_wdata;
   logic [63:0] dmem_addr;
   logic        dmem_wen;
   logic [63:0] dmem_wdata;
   logic        cpu_enable;
   logic        busy;
   logic        err;
`ifdef CPU_LOADER_CHECKSUM_EN
   logic [31:0] checksum;
`endif

   cpu_program_loader dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .imem_addr  (imem_addr),
      .imem_wen   (imem_wen),
      .imem_wdata (imem_wdata),
      .dmem_addr  (dmem_addr),
      .dmem_wen   (dmem_wen),
      .dmem_wdata (dmem_wdata),
      .cpu_enable (cpu_enable),
      .busy       (busy),
      .err        (err)
`ifdef CPU_LOADER_CHECKSUM_EN
     ,.checksum   (checksum)
`endif
   );

   typedef struct {
      logic        is_dmem;
      logic [63:0] addr;
      logic [63:0] data;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
      end
   endtask

   task automatic push_i(input logic [63:0] addr, input logic [31:0] data);
      exp_t e;
      e.is_dmem = 1'b0;
      e.addr    = addr;
      e.data    = {32'd0, data};
      sb.push_back(e);
   endtask

   task automatic push_d(input logic [63:0] addr, input logic [63:0] data);
      exp_t e;
      e.is_dmem = 1'b1;
      e.addr    = addr;
      e.data    = data;
      sb.push_back(e);
   endtask

   // One beat; called #1 after a rising edge, returns #1 after the beat edge.
   task automatic send(input logic [31:0] w);
      int guard;
      guard    = 0;
      in_data  = w;
      in_valid = 1'b1;
      while (!in_ready && guard < 20) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (!in_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: in_ready stayed %b for word 0x%h", in_ready, w);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain(input string name);
      int g;
      g = 0;
      while (sb.size() != 0 && g < 20) begin
         @(posedge clk);
         #1;
         g++;
      end
      chk(name, 64'(sb.size()), 64'd0);
   endtask

   // Monitor: every write pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (imem_wen === 1'b1 && dmem_wen === 1'b1) begin
         n_checks++;
         n_fail++;
         $display("FAIL dual_write: imem_wen and dmem_wen both high");
      end
      if (imem_wen === 1'b1) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL imem_write: unexpected write addr=0x%h data=0x%h", imem_addr, imem_wdata);
         end else begin
            e = sb.pop_front();
            if (e.is_dmem || imem_addr !== e.addr || {32'd0, imem_wdata} !== e.data) begin
               n_fail++;
               $display("FAIL imem_write: got addr=0x%h data=0x%h expected dmem=%0d addr=0x%h data=0x%h",
                        imem_addr, imem_wdata, e.is_dmem, e.addr, e.data);
            end
         end
      end
      if (dmem_wen === 1'b1) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL dmem_write: unexpected write addr=0x%h data=0x%h", dmem_addr, dmem_wdata);
         end else begin
            e = sb.pop_front();
            if (!e.is_dmem || dmem_addr !== e.addr || dmem_wdata !== e.data) begin
               n_fail++;
               $display("FAIL dmem_write: got addr=0x%h data=0x%h expected dmem=%0d addr=0x%h data=0x%h",
                        dmem_addr, dmem_wdata, e.is_dmem, e.addr, e.data);
            end
         end
      end
   end

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_err", {63'd0, err}, 64'd0);
      chk("rst_cpu_enable", {63'd0, cpu_enable}, 64'd0);
      chk("rst_imem_addr", imem_addr, 64'd0);
      chk("rst_dmem_wdata", dmem_wdata, 64'd0);
`ifdef CPU_LOADER_CHECKSUM_EN
      chk("rst_checksum", {32'd0, checksum}, 64'd0);
`endif

      // IMEM burst, back-to-back beats
      send(32'h0000_0003);
      chk("imem_busy_hdr", {63'd0, busy}, 64'd1);
      push_i(64'h0, 32'h0000_0013);
      push_i(64'h4, 32'h0010_0093);
      push_i(64'h8, 32'h0020_8113);
      send(32'h0000_0013);
      send(32'h0010_0093);
      chk("imem_busy_mid", {63'd0, busy}, 64'd1);
      send(32'h0020_8113);
      chk("imem_busy_end", {63'd0, busy}, 64'd0);
      drain("imem_drain");
      chk("imem_addr_hold", imem_addr, 64'h8);
      chk("imem_wdata_hold", {32'd0, imem_wdata}, 64'h0020_8113);

      // DMEM burst with a 2-cycle stall between halves
      send(32'h8002_0001);
      push_d(64'h10, 64'h0123_4567_DEAD_BEEF);
      send(32'hDEAD_BEEF);
      idle(2);
      chk("dmem_busy_stall", {63'd0, busy}, 64'd1);
      send(32'h0123_4567);
      drain("dmem_drain");

      // IMEM range error: skip 2 beats, then a normal burst
      send(32'h01FF_0002);
      chk("oob_err", {63'd0, err}, 64'd1);
      chk("oob_busy", {63'd0, busy}, 64'd1);
      send(32'h1111_1111);
      send(32'h2222_2222);
      chk("oob_skip_done", {63'd0, busy}, 64'd0);
      send(32'h0005_0001);
      push_i(64'h14, 32'hCAFE_F00D);
      send(32'hCAFE_F00D);
      drain("after_oob_drain");
      chk("err_sticky", {63'd0, err}, 64'd1);

      // Boundaries: B+N equal to depth is legal
      send(32'h01FF_0001);
      push_i(64'h7FC, 32'h5555_AAAA);
      send(32'h5555_AAAA);
      send(32'h83FF_0001);
      push_d(64'h1FF8, 64'h3333_4444_1111_2222);
      send(32'h1111_2222);
      send(32'h3333_4444);
      drain("boundary_drain");

      // DMEM range error skips 2N beats
      send(32'h83FF_0002);
      send(32'h0000_0001);
      send(32'h0000_0002);
      send(32'h0000_0003);
      chk("dmem_skip_3of4", {63'd0, busy}, 64'd1);
      send(32'h0000_0004);
      chk("dmem_skip_done", {63'd0, busy}, 64'd0);

      // Reset mid-burst
      send(32'h0000_0003);
      push_i(64'h0, 32'hAAAA_0001);
      send(32'hAAAA_0001);
      in_data  = 32'hAAAA_0002;
      in_valid = 1'b1;
      rst      = 1'b1;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("mid_rst_busy", {63'd0, busy}, 64'd0);
      chk("mid_rst_err", {63'd0, err}, 64'd0);
      chk("mid_rst_imem_addr", imem_addr, 64'd0);
      chk("mid_rst_imem_wdata", {32'd0, imem_wdata}, 64'd0);
      chk("mid_rst_dmem_addr", dmem_addr, 64'd0);
      idle(3);
      drain("mid_rst_drain");
      send(32'h0000_0000);
      chk("noop_busy", {63'd0, busy}, 64'd0);
      send(32'h0007_0001);
      push_i(64'h1C, 32'h0000_0077);
      send(32'h0000_0077);
      drain("post_rst_drain");

      // Start: cpu enabled, no further input accepted
      send(32'h4000_0000);
      chk("run_cpu_enable", {63'd0, cpu_enable}, 64'd1);
      chk("run_in_ready", {63'd0, in_ready}, 64'd0);
      chk("run_busy", {63'd0, busy}, 64'd0);
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_data = 32'h0000_0001 + 32'(i);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      chk("run_hold_enable", {63'd0, cpu_enable}, 64'd1);
      chk("run_hold_ready", {63'd0, in_ready}, 64'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("run_rst_enable", {63'd0, cpu_enable}, 64'd0);
      chk("run_rst_ready", {63'd0, in_ready}, 64'd1);

`ifdef CPU_LOADER_CHECKSUM_EN
      send(32'h0000_0002);
      push_i(64'h0, 32'hFFFF_FFFF);
      push_i(64'h4, 32'h0000_0002);
      send(32'hFFFF_FFFF);
      send(32'h0000_0002);
      drain("csum_drain");
      chk("checksum", {32'd0, checksum}, 64'h0000_0001);
`endif

      idle(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
